// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
//   Owns the PC, runs a req/ack handshake with instruction memory and presents
//   {Instr, PC, Valid} to the F/D pipeline register. Handles stalls (FDEn_I low),
//   branch/jump redirects and exception redirects (exception has priority).
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous active-low reset
//   FDEn_I         F/D register loads this cycle
//   Redirect_I     branch/jump taken, target on RedirectPC_I
//   RedirectPC_I   redirect target
//   Exc_I          exception/eret redirect to EXC_PC
//   imem_req_O     memory request, held until imem_ack_I
//   imem_addr_O    request address, stable while imem_req_O=1
//   imem_ack_I     memory completes the request this cycle
//   imem_rdata_I   instruction word returned with imem_ack_I
//   Instr_O        instruction to F/D register (0 when not valid)
//   PC_O           PC of Instr_O, or current pc when not valid
//   Valid_O        Instr_O/PC_O hold a fetched or faulted instruction
//   AddrErr_O      held PC is misaligned; Instr_O is 0
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        FDEn_I,
    input  logic        Redirect_I,
    input  logic [31:0] RedirectPC_I,
    input  logic        Exc_I,
    output logic        imem_req_O,
    output logic [31:0] imem_addr_O,
    input  logic        imem_ack_I,
    input  logic [31:0] imem_rdata_I,
    output logic [31:0] Instr_O,
    output logic [31:0] PC_O,
    output logic        Valid_O,
    output logic        AddrErr_O
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FULL,
        DRAIN
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_addr_q;
    logic [31:0] w_addr_nxt;
    logic [31:0] r_buf;
    logic [31:0] w_buf_nxt;
    logic        r_addr_err;
    logic        w_addr_err_nxt;

    logic        w_redir;
    logic [31:0] w_target;
    logic        w_misaligned;
    logic [31:0] w_pc_inc;

    assign w_redir      = Exc_I | Redirect_I;
    assign w_target     = Exc_I ? EXC_PC : RedirectPC_I;
    // addr_q equals pc whenever REQ is entered, so it stands in for pc here
    assign w_misaligned = (r_addr_q[1:0] != 2'b00);
    assign w_pc_inc     = r_pc + 32'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_addr_q   <= RESET_PC;
            r_buf      <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_addr_q   <= w_addr_nxt;
            r_buf      <= w_buf_nxt;
            r_addr_err <= w_addr_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_addr_nxt     = r_addr_q;
        w_buf_nxt      = r_buf;
        w_addr_err_nxt = r_addr_err;

        imem_req_O     = 1'b0;
        imem_addr_O    = r_addr_q;
        Valid_O        = 1'b0;
        AddrErr_O      = 1'b0;
        Instr_O        = '0;
        PC_O           = r_pc;

        case (r_state)
            IDLE: begin
                w_state_nxt = REQ;
            end

            REQ: begin
                if (w_misaligned) begin
                    // No request goes out, so a redirect can retarget
                    // directly instead of waiting in DRAIN for an ack.
                    if (w_redir) begin
                        w_pc_nxt   = w_target;
                        w_addr_nxt = w_target;
                    end else begin
                        w_buf_nxt      = '0;
                        w_addr_err_nxt = 1'b1;
                        w_state_nxt    = FULL;
                    end
                end else begin
                    imem_req_O = 1'b1;
                    if (w_redir) begin
                        w_pc_nxt = w_target;
                        if (imem_ack_I) begin
                            w_addr_nxt = w_target;
                        end else begin
                            w_state_nxt = DRAIN;
                        end
                    end else if (imem_ack_I) begin
                        w_buf_nxt      = imem_rdata_I;
                        w_addr_err_nxt = 1'b0;
                        w_state_nxt    = FULL;
                    end
                end
            end

            FULL: begin
                Valid_O   = 1'b1;
                Instr_O   = r_buf;
                AddrErr_O = r_addr_err;
                if (w_redir) begin
                    w_pc_nxt       = w_target;
                    w_addr_nxt     = w_target;
                    w_buf_nxt      = '0;
                    w_addr_err_nxt = 1'b0;
                    w_state_nxt    = REQ;
                end else if (FDEn_I) begin
                    w_pc_nxt    = w_pc_inc;
                    w_addr_nxt  = w_pc_inc;
                    w_state_nxt = REQ;
                end
            end

            DRAIN: begin
                imem_req_O = 1'b1;
                if (w_redir) begin
                    w_pc_nxt = w_target;
                end
                if (imem_ack_I) begin
                    // the latest redirect wins, including one in the ack cycle
                    w_addr_nxt  = w_redir ? w_target : r_pc;
                    w_state_nxt = REQ;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage: owns the PC and runs a req/ack handshake with instruction memory.
- Presents {Instr, PC, Valid} to the F/D pipeline register, which loads them when its FDEn enable is high.
- Handles stalls (FDEn low), branch/jump redirects and exception redirects.
- Drives a NOP (0x0000_0000) whenever no valid instruction is held.

Parameters:
- RESET_PC, 32'h0000_3000, PC fetched first after reset.
- EXC_PC, 32'h0000_4180, exception handler entry.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; asserted while 0.
- FDEn_I  in  1  downstream accept; F/D register loads this cycle when 1.
- Redirect_I  in  1  branch/jump taken; target on RedirectPC_I.
- RedirectPC_I  in  32  redirect target.
- Exc_I  in  1  exception/eret redirect to EXC_PC; priority over Redirect_I.
- imem_req_O  out  1  memory request; held until imem_ack_I.
- imem_addr_O  out  32  request address; stable while imem_req_O=1.
- imem_ack_I  in  1  memory completes the request this cycle; imem_rdata_I is valid.
- imem_rdata_I  in  32  instruction word.
- Instr_O  out  32  instruction to F/D register; 0 when Valid_O=0.
- PC_O  out  32  PC of Instr_O; equals the current pc register when invalid.
- Valid_O  out  1  Instr_O/PC_O hold a real fetched or faulted instruction.
- AddrErr_O  out  1  the held PC is misaligned (pc[1:0]!=0); Instr_O=0.

Behaviour:

Reset:
- While reset=0: state=IDLE, pc=RESET_PC, addr_q=RESET_PC, buf=0.
- Outputs during reset: imem_req_O=0, Valid_O=0, AddrErr_O=0, Instr_O=0, PC_O=RESET_PC.
- Reset mid-transaction abandons everything; memory must tolerate the request being dropped.

States:
- IDLE -> REQ unconditionally on the next edge. The first request appears 1 cycle after reset release.
- REQ:
  - Outputs: imem_req_O=1, imem_addr_O=addr_q (addr_q=pc on entry).
  - pc[1:0]!=0 on entry: no request is issued; go FULL with AddrErr_O=1, buf=0.
  - ack=1: buf<=rdata, go FULL.
  - Zero-wait ack (ack in the first REQ cycle) is legal.
- FULL:
  - Outputs: Valid_O=1, Instr_O=buf, PC_O=pc.
  - FDEn_I=1: pc<=pc+4 (32-bit wrap), addr_q<=pc+4, go REQ.
  - FDEn_I=0 (stall): hold all outputs unchanged indefinitely.
- DRAIN:
  - A request is still outstanding after a redirect.
  - Outputs: imem_req_O=1, imem_addr_O=old addr_q, Valid_O=0.
  - On ack: discard data, addr_q<=pc, go REQ.

Redirects:
- Target: Exc_I -> EXC_PC, else Redirect_I -> RedirectPC_I.
- Sampled every non-IDLE cycle; pc<=target immediately.
- FULL: drop buf, addr_q<=target, go REQ (Valid_O=0 next cycle). FDEn_I is ignored that cycle.
- REQ with ack=1 same cycle: discard data, addr_q<=target, go REQ.
- REQ with ack=0: go DRAIN; addr_q is unchanged.
- DRAIN: pc<=target again (latest wins); stay DRAIN until ack.

Timing:
- Fetch latency from REQ entry to Valid_O=1 = ack delay + 1 cycle.
- Zero-wait memory sustains 1 instruction per 2 cycles.
- No instruction is ever presented twice or skipped, except those discarded by a redirect.

Test Plan:
- Reset release, zero-wait memory, FDEn_I=1: imem_addr_O sequence 0x3000, 0x3004, 0x3008; Valid_O pulses with PC_O 0x3000, 0x3004 and the matching Instr_O.
- Stall: hold FDEn_I=0 for 5 cycles in FULL at PC 0x3008 -> Instr_O/PC_O constant, imem_req_O=0; release -> next request at 0x300C.
- Branch in FULL (Redirect_I=1, RedirectPC_I=0x3100) -> Valid_O=0 next cycle, next request at 0x3100, then PC_O=0x3100.
- Redirect while ack delayed 3 cycles at 0x3004 -> DRAIN holds imem_addr_O=0x3004 until ack, data discarded, next request at target, old word never valid.
- Exc_I and Redirect_I together in FULL -> next fetch at 0x4180; RedirectPC_I=0x3102 alone -> Valid_O=1, AddrErr_O=1, Instr_O=0, PC_O=0x3102, no memory request.
- Assert reset low during DRAIN -> outputs immediately at reset values; after release, request at 0x3000.
